// File: rtl/mem_port_arbiter_pkg.sv
//------------------------------------------------------------------------------
// Module  : mem_port_arbiter_pkg
// Brief   : Shared encodings for the unified I/D memory port arbiter.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mem_port_arbiter_pkg;

  localparam logic [1:0]  c_mem_none  = 2'b00;
  localparam logic [1:0]  c_mem_byte  = 2'b01;
  localparam logic [1:0]  c_mem_half  = 2'b10;
  localparam logic [1:0]  c_mem_word  = 2'b11;

  localparam logic [31:0] c_nop_instr = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IF = 2'd1,
    ST_BUSY_MA = 2'd2
  } arb_state_t;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_MA = 1'b1
  } port_t;

endpackage

`default_nettype wire

// File: rtl/mem_timeout_counter.sv
//------------------------------------------------------------------------------
// Module  : mem_timeout_counter
// Brief   : Counts request cycles without ready; o_tc flags the abort edge.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tc
);

  // tc fires on the edge that would bring the count up to TIMEOUT_CYCLES,
  // so mem_req is high for exactly TIMEOUT_CYCLES cycles before the abort.
  localparam logic [15:0] c_last = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_count;

  assign o_tc = i_enable & (r_count == c_last);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 16'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
//------------------------------------------------------------------------------
// Module  : mem_port_arbiter
// Brief   : Round-robin IF/MA arbiter for a single-ported unified memory.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] NOP_INSTR      = c_nop_instr
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic [1:0]  ma_read,
  input  logic [1:0]  ma_write,
  input  logic [31:0] ma_addr,
  input  logic [31:0] ma_wdata,
  output logic [31:0] ma_rdata,
  output logic        ma_valid,
  output logic        stall_if,
  output logic        stall_ma,
  output logic        mem_req,
  output logic        mem_we,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        timeout_err
);

  arb_state_t  r_state, w_state_nxt;
  port_t       r_last_grant;
  logic        r_mem_req, r_mem_we;
  logic [1:0]  r_mem_size;
  logic [31:0] r_mem_addr, r_mem_wdata;
  logic [31:0] r_if_rdata, r_ma_rdata;
  logic        r_if_valid, r_ma_valid, r_kill, r_timeout_err;

  logic        w_ma_active, w_ma_we;
  logic [1:0]  w_ma_size;
  logic        w_grant_if, w_grant_ma;
  logic        w_tc, w_ready, w_done, w_if_drop;

  assign w_ma_active = (ma_read != c_mem_none) | (ma_write != c_mem_none);
  assign w_ma_we     = (ma_write != c_mem_none);
  assign w_ma_size   = w_ma_we ? ma_write : ma_read;

  // Gated by reset so every output reads 0 while reset is asserted.
  assign stall_if = reset & if_req & ~r_if_valid;
  assign stall_ma = reset & w_ma_active & ~r_ma_valid;

  assign w_ready   = r_mem_req & mem_ready;
  assign w_done    = w_ready | w_tc;
  assign w_if_drop = r_kill | if_flush;

  mem_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_grant_if | w_grant_ma),
    .i_enable (r_mem_req & ~mem_ready),
    .o_tc     (w_tc)
  );

  // A port only competes while it is stalled, so a port pulsing valid is
  // never re-granted with its stale operands.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_if  = 1'b0;
    w_grant_ma  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (stall_if && stall_ma) begin
          if (r_last_grant == PORT_IF) w_grant_ma = 1'b1;
          else                         w_grant_if = 1'b1;
        end else begin
          w_grant_if = stall_if;
          w_grant_ma = stall_ma;
        end
        if (w_grant_if)      w_state_nxt = ST_BUSY_IF;
        else if (w_grant_ma) w_state_nxt = ST_BUSY_MA;
      end
      ST_BUSY_IF, ST_BUSY_MA: begin
        if (w_done) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_grant  <= PORT_IF;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_size    <= c_mem_none;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_if_rdata    <= '0;
      r_ma_rdata    <= '0;
      r_if_valid    <= 1'b0;
      r_ma_valid    <= 1'b0;
      r_kill        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_if_valid <= 1'b0;
      r_ma_valid <= 1'b0;

      if (w_grant_if) begin
        r_mem_req    <= 1'b1;
        r_mem_we     <= 1'b0;
        r_mem_size   <= c_mem_word;
        r_mem_addr   <= if_addr;
        r_mem_wdata  <= '0;
        r_last_grant <= PORT_IF;
      end else if (w_grant_ma) begin
        r_mem_req    <= 1'b1;
        r_mem_we     <= w_ma_we;
        r_mem_size   <= w_ma_size;
        r_mem_addr   <= ma_addr;
        r_mem_wdata  <= ma_wdata;
        r_last_grant <= PORT_MA;
      end else if (w_done) begin
        r_mem_req <= 1'b0;
      end

      if (w_tc) r_timeout_err <= 1'b1;

      // A killed fetch still finishes on the bus but never reaches IF.
      if (r_state == ST_BUSY_IF) begin
        if (w_done) begin
          r_kill <= 1'b0;
          if (!w_if_drop) begin
            r_if_valid <= 1'b1;
            r_if_rdata <= w_ready ? mem_rdata : NOP_INSTR;
          end
        end else if (if_flush) begin
          r_kill <= 1'b1;
        end
      end

      if ((r_state == ST_BUSY_MA) && w_done) begin
        r_ma_valid <= 1'b1;
        if (!r_mem_we) r_ma_rdata <= w_ready ? mem_rdata : '0;
      end
    end
  end

  assign mem_req     = r_mem_req;
  assign mem_we      = r_mem_we;
  assign mem_size    = r_mem_size;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign if_rdata    = r_if_rdata;
  assign if_valid    = r_if_valid;
  assign ma_rdata    = r_ma_rdata;
  assign ma_valid    = r_ma_valid;
  assign timeout_err = r_timeout_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
//------------------------------------------------------------------------------
// Module  : tb_mem_port_arbiter
// Brief   : Scoreboard bench for mem_port_arbiter with a latency-driven memory.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_flush;
  logic [31:0] if_addr, if_rdata;
  logic        if_valid;
  logic [1:0]  ma_read, ma_write;
  logic [31:0] ma_addr, ma_wdata, ma_rdata;
  logic        ma_valid, stall_if, stall_ma;
  logic        mem_req, mem_we;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        timeout_err;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .TIMEOUT_CYCLES (8),
    .NOP_INSTR      (32'h0000_0013)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_flush    (if_flush),
    .if_rdata    (if_rdata),
    .if_valid    (if_valid),
    .ma_read     (ma_read),
    .ma_write    (ma_write),
    .ma_addr     (ma_addr),
    .ma_wdata    (ma_wdata),
    .ma_rdata    (ma_rdata),
    .ma_valid    (ma_valid),
    .stall_if    (stall_if),
    .stall_ma    (stall_ma),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_size    (mem_size),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .timeout_err (timeout_err)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  txn_t        exp_txn[$];
  logic [31:0] exp_if[$];
  logic [31:0] exp_ma[$];
  txn_t        cur;
  bit          have_cur     = 1'b0;
  int          n_checks     = 0;
  int          n_fails      = 0;
  int          lat          = 1;
  bit          stuck        = 1'b0;
  bit          idle_ready   = 1'b0;
  int          req_cycles   = 0;
  int          last_req_len = 0;
  logic [31:0] ma_model     = '0;
  int          n;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic txn_t mk_txn(input logic [31:0] addr, input logic we,
                                  input logic [1:0] size, input logic [31:0] wdata,
                                  input logic [31:0] rdata);
    txn_t t;
    t.addr = addr; t.we = we; t.size = size; t.wdata = wdata; t.rdata = rdata;
    return t;
  endfunction

  // Memory model: pops the expected transaction on the first request cycle,
  // checks the bus every request cycle and answers after 'lat' cycles.
  always @(negedge clk) begin
    if (mem_req) begin
      if (req_cycles == 0) begin
        if (exp_txn.size() == 0) check("txn_unexpected", 1, 0);
        else begin
          cur      = exp_txn.pop_front();
          have_cur = 1'b1;
        end
      end
      if (have_cur) begin
        check("mem_addr", mem_addr, cur.addr);
        check("mem_we_size", {mem_we, mem_size}, {cur.we, cur.size});
        if (cur.we) check("mem_wdata", mem_wdata, cur.wdata);
        mem_rdata = cur.rdata;
      end
      req_cycles++;
      mem_ready = !stuck && (req_cycles >= lat);
    end else begin
      if (req_cycles != 0) last_req_len = req_cycles;
      req_cycles = 0;
      have_cur   = 1'b0;
      mem_ready  = idle_ready;
    end
  end

  always @(negedge clk) begin
    if (if_valid) begin
      if (exp_if.size() == 0) check("if_valid_unexpected", 1, 0);
      else check("if_rdata", if_rdata, exp_if.pop_front());
    end
    if (ma_valid) begin
      if (exp_ma.size() == 0) check("ma_valid_unexpected", 1, 0);
      else check("ma_rdata", ma_rdata, exp_ma.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // chk: 1 = stall_if must be high until valid, 2 = stall_ma must be high.
  task automatic wait_valid(input bit is_ma, input string tag, input int chk, output int cycles);
    int k;
    for (k = 0; k < 60; k++) begin
      @(negedge clk);
      if (is_ma ? ma_valid : if_valid) break;
      if (chk == 1) check({tag, "_stall_if"}, stall_if, 1);
      if (chk == 2) check({tag, "_stall_ma"}, stall_ma, 1);
    end
    if (k == 60) check({tag, "_valid_timeout"}, 0, 1);
    cycles = k + 1;
  endtask

  task automatic wait_req(input logic level, input string tag);
    int k;
    for (k = 0; k < 30; k++) begin
      @(negedge clk);
      if (mem_req == level) break;
    end
    if (k == 30) check({tag, "_req_timeout"}, 0, 1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    #1 reset = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; if_req = 1'b1; if_flush = 1'b0; if_addr = 32'h0;
    ma_read = 2'b11; ma_write = 2'b00; ma_addr = '0; ma_wdata = '0;
    #12;
    check("rst_mem_ctl", {mem_req, mem_we, mem_size, mem_addr}, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_valids_err", {if_valid, ma_valid, timeout_err}, 0);
    check("rst_stalls", {stall_if, stall_ma}, 0);
    check("rst_rdata", {if_rdata, ma_rdata}, 0);
    if_req = 1'b0; ma_read = 2'b00;
    @(negedge clk);
    #1 reset = 1'b1;
    tick();

    // single fetch
    exp_txn.push_back(mk_txn(32'h100, 1'b0, 2'b11, 32'h0, 32'h0050_0093));
    exp_if.push_back(32'h0050_0093);
    if_addr = 32'h100; if_req = 1'b1;
    wait_valid(1'b0, "fetch", 1, n);
    check("fetch_latency", n, 3);
    check("fetch_stall_if_low", stall_if, 0);
    tick(); if_req = 1'b0;

    // ties after reset: MA, IF, then MA again
    do_reset();
    exp_txn.push_back(mk_txn(32'h2000, 1'b0, 2'b11, 32'h0, 32'hDEAD_BEEF));
    exp_txn.push_back(mk_txn(32'h200, 1'b0, 2'b11, 32'h0, 32'h1111_1111));
    exp_ma.push_back(32'hDEAD_BEEF); ma_model = 32'hDEAD_BEEF;
    exp_if.push_back(32'h1111_1111);
    if_addr = 32'h200; if_req = 1'b1; ma_addr = 32'h2000; ma_read = 2'b11;
    wait_valid(1'b1, "tie1_ma", 2, n);
    check("tie1_ma_latency", n, 3);
    tick(); ma_read = 2'b00;
    wait_valid(1'b0, "tie1_if", 0, n);
    check("tie1_if_latency", n, 2);
    tick(); if_req = 1'b0;
    tick();
    exp_txn.push_back(mk_txn(32'h2004, 1'b0, 2'b11, 32'h0, 32'h2222_2222));
    exp_txn.push_back(mk_txn(32'h204, 1'b0, 2'b11, 32'h0, 32'h3333_3333));
    exp_ma.push_back(32'h2222_2222); ma_model = 32'h2222_2222;
    exp_if.push_back(32'h3333_3333);
    if_addr = 32'h204; if_req = 1'b1; ma_addr = 32'h2004; ma_read = 2'b11;
    wait_valid(1'b1, "tie2_ma", 0, n);
    tick(); ma_read = 2'b00;
    wait_valid(1'b0, "tie2_if", 0, n);
    tick(); if_req = 1'b0;

    // byte store with 4-cycle ready latency
    lat = 4;
    exp_txn.push_back(mk_txn(32'h3003, 1'b1, 2'b01, 32'hAB, 32'h5555_5555));
    exp_ma.push_back(ma_model);
    ma_addr = 32'h3003; ma_wdata = 32'hAB; ma_write = 2'b01;
    wait_valid(1'b1, "store", 2, n);
    check("store_latency", n, 6);
    tick(); ma_write = 2'b00; lat = 1;
    check("store_req_len", last_req_len, 4);

    // flush mid-fetch, then refetch at the new PC
    lat = 3;
    exp_txn.push_back(mk_txn(32'h400, 1'b0, 2'b11, 32'h0, 32'h9999_9999));
    exp_txn.push_back(mk_txn(32'h800, 1'b0, 2'b11, 32'h0, 32'h0AA0_0A13));
    exp_if.push_back(32'h0AA0_0A13);
    if_addr = 32'h400; if_req = 1'b1;
    wait_req(1'b1, "flush");
    tick(); if_flush = 1'b1; if_addr = 32'h800;
    tick(); if_flush = 1'b0;
    wait_req(1'b0, "flush_done");
    check("flush_if_rdata_kept", if_rdata, 32'h3333_3333);
    check("flush_no_valid", if_valid, 0);
    wait_valid(1'b0, "refetch", 0, n);
    tick(); if_req = 1'b0; lat = 1;

    // timeout on a fetch with memory never answering
    check("timeout_err_clear", timeout_err, 0);
    stuck = 1'b1;
    exp_txn.push_back(mk_txn(32'h500, 1'b0, 2'b11, 32'h0, 32'hFFFF_FFFF));
    exp_if.push_back(32'h0000_0013);
    if_addr = 32'h500; if_req = 1'b1;
    wait_valid(1'b0, "tmo_fetch", 1, n);
    tick(); if_req = 1'b0; stuck = 1'b0;
    check("tmo_req_len", last_req_len, 8);
    check("timeout_err_set", timeout_err, 1);
    exp_txn.push_back(mk_txn(32'h504, 1'b0, 2'b11, 32'h0, 32'h0010_0073));
    exp_if.push_back(32'h0010_0073);
    if_addr = 32'h504; if_req = 1'b1;
    wait_valid(1'b0, "post_tmo_fetch", 0, n);
    tick(); if_req = 1'b0;
    check("timeout_err_sticky", timeout_err, 1);

    // asynchronous reset while MA is busy
    lat = 10;
    exp_txn.push_back(mk_txn(32'h6000, 1'b0, 2'b11, 32'h0, 32'h7777_7777));
    ma_addr = 32'h6000; ma_read = 2'b11;
    wait_req(1'b1, "arst");
    #2 reset = 1'b0;
    #1;
    check("arst_mem_req", mem_req, 0);
    check("arst_stall_ma", stall_ma, 0);
    check("arst_valids", {if_valid, ma_valid}, 0);
    check("arst_timeout_err", timeout_err, 0);
    ma_read = 2'b00; lat = 1; idle_ready = 1'b1;
    @(negedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_after_arst", {mem_req, stall_ma, stall_if}, 0);
    end
    idle_ready = 1'b0;
    tick();
    exp_txn.push_back(mk_txn(32'h6004, 1'b0, 2'b10, 32'h0, 32'h1234_5678));
    exp_ma.push_back(32'h1234_5678); ma_model = 32'h1234_5678;
    ma_addr = 32'h6004; ma_read = 2'b10;
    wait_valid(1'b1, "post_arst_load", 2, n);
    check("post_arst_latency", n, 3);
    tick(); ma_read = 2'b00;
    tick();

    check("txn_queue_drained", exp_txn.size(), 0);
    check("if_queue_drained", exp_if.size(), 0);
    check("ma_queue_drained", exp_ma.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-ported unified instruction/data memory between the IF stage fetch and the MA stage load/store of the 5-stage RV32IM pipeline. It runs a one-outstanding-transaction req/ready handshake toward memory and generates the stall signals the pipeline uses while a port waits. It also discards fetches killed by a taken branch and flags memory that never answers.

Parameters:
TIMEOUT_CYCLES, 255, cycles mem_req may stay high without mem_ready before abort (1..65535)
NOP_INSTR, 32'h00000013, instruction returned to IF on a timed-out fetch

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
if_req  input  1  IF wants a fetch at if_addr
if_addr  input  32  fetch address (pc_out)
if_flush  input  1  taken branch/jump (pc_sel_ma); kills the in-flight fetch
if_rdata  output  32  fetched instruction, valid with if_valid
if_valid  output  1  one-cycle pulse: fetch complete
ma_read  input  2  00 none, 01 byte, 10 half, 11 word
ma_write  input  2  same encoding
ma_addr  input  32  data address (alu_result_ma)
ma_wdata  input  32  store data
ma_rdata  output  32  load data, valid with ma_valid
ma_valid  output  1  one-cycle pulse: data access complete
stall_if  output  1  freeze PC and IF_ID
stall_ma  output  1  freeze all pipeline registers
mem_req  output  1  memory request
mem_we  output  1  1 = write
mem_size  output  2  access size, same encoding as ma_read
mem_addr  output  32  memory address
mem_wdata  output  32  memory write data
mem_rdata  input  32  memory read data
mem_ready  input  1  completes the transaction on the edge where mem_req=1
timeout_err  output  1  sticky error flag

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0; last_grant=IF, so MA wins the first tie; timeout counter 0; kill flag 0.
- ma_active = (ma_read!=0)|(ma_write!=0). If both are nonzero, the access is a write with size ma_write.
- Requesters hold request and operands stable until their valid pulse; the stalls guarantee this.
- stall_if = if_req & ~if_valid; stall_ma = ma_active & ~ma_valid. Both are combinational.
- FSM states: IDLE, BUSY_IF, BUSY_MA.
- IDLE, one requester: grant it. IDLE, both: grant the port opposite last_grant (round robin). IDLE, none: stay.
- Grant: register addr/we/size/wdata into the mem_* outputs; mem_req=1 from the next cycle; update last_grant. IF fetches use size 11, we=0.
- BUSY_x: hold mem_* stable. On an edge with mem_ready=1:
  - register mem_rdata into x_rdata (writes leave ma_rdata unchanged);
  - pulse x_valid for the following cycle;
  - drop mem_req; return to IDLE.
- Minimum access time is 3 cycles from request to valid pulse: grant, req+ready, valid. No back-to-back grant; IDLE always intervenes.
- x_rdata holds its value until the next completion on that port.
- if_flush during BUSY_IF, or on the completion edge: set kill. The transaction still completes on memory, but if_valid is suppressed and if_rdata is not updated. kill clears on return to IDLE.
- if_flush in IDLE: no effect. if_flush during BUSY_MA: no effect.
- Timeout: a 16-bit counter increments each cycle with mem_req=1 & mem_ready=0 and clears on grant. When it reaches TIMEOUT_CYCLES:
  - drop mem_req; set timeout_err (held until reset);
  - complete the port with rdata NOP_INSTR (IF) or 0 (MA) and pulse valid; kill still applies.
- mem_ready while mem_req=0 is ignored.
- Reset mid-transaction aborts immediately: mem_req=0, no valid pulse.

Decomposition:
- Shared header mem_defs.vh holds: size encodings (MEM_NONE, MEM_BYTE, MEM_HALF, MEM_WORD), FSM state encodings, and the NOP constant.
- One sub-module, mem_timeout_counter: clear/enable/terminal-count, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Single fetch: if_req=1, if_addr=0x100, mem_ready 1 cycle after mem_req, mem_rdata=0x00500093 -> mem_addr=0x100, mem_we=0, size=11; if_valid pulses once; if_rdata=0x00500093; stall_if falls the same cycle.
- Simultaneous requests after reset: if_req=1, ma_read=11 @0x2000 -> MA granted first; then IF; a third tie grants MA again (alternation).
- Store with ready latency 4: ma_write=01, addr 0x3003, wdata 0xAB -> mem_we=1, size=01, mem_* stable 4 cycles; stall_ma high until the ma_valid pulse; ma_rdata unchanged.
- Flush mid-fetch: if_flush pulses in BUSY_IF -> no if_valid, if_rdata keeps its old value; the next if_req at the new PC completes normally.
- Timeout with TIMEOUT_CYCLES=8, mem_ready stuck 0 on a fetch -> mem_req falls after 8 cycles; if_valid with 0x00000013; timeout_err=1 until reset.
- Async reset asserted in BUSY_MA -> mem_req, stall_ma and valids go 0 without waiting for clk; state IDLE on release.
